pwm_capture: RTL and testbench
==============================

# pwm_capture

Multi-channel PWM pulse-width and period capture for the MAXSONAR range-finder path. Each channel synchronises an asynchronous PWM input, measures high time and optionally rising-to-rising period in `clk` cycles, and publishes each result with a one-cycle strobe. Channels stall-detect with a timeout flag. Sits between the sonar pins and the AXI register front-end of the MAXSONAR processor IP.

## Interface
- `NUM_CH`, 3: number of independent channels (≥1).
- `CNT_W`, 32: counter/result width in bits (≥4).
- `SYNC_STAGES`, 2: input synchroniser flops per channel (≥2).
- `TIMEOUT_CYC`, 10_000_000: idle cycles (no edge) before timeout; must be < 2^CNT_W.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `pwm`  in  NUM_CH  raw asynchronous PWM inputs, bit i = channel i.
- `high_len`  out  NUM_CH*CNT_W  last completed high time, channel i in bits [i*CNT_W +: CNT_W].
- `high_valid`  out  NUM_CH  one-cycle strobe when `high_len` slice updates.
- `period_len`  out  NUM_CH*CNT_W  last rising-to-rising period (macro-dependent).
- `period_valid`  out  NUM_CH  one-cycle strobe when `period_len` slice updates.
- `timeout`  out  NUM_CH  level: channel saw no edge for TIMEOUT_CYC cycles.

## Operation
- Per channel: `s` = synchronised input, `s_d` = `s` delayed one cycle. Rise = `s & ~s_d`; fall = `~s & s_d`.
- All counters saturate at 2^CNT_W−1 and hold; no wrap.
- High counter `hi_cnt`: rise → 1; `s`=1 and no rise → sat(hi_cnt+1); fall → `high_len` ← `hi_cnt`, `high_valid` ← 1, `hi_cnt` ← 0. Result = exact number of cycles `s` was high.
- A fall is published only if channel `armed` (rise seen since reset/timeout); otherwise ignored, no strobe.
- Period counter `per_cnt`: rise → if `armed`, `period_len` ← `per_cnt`, `period_valid` ← 1; then `per_cnt` ← 1, `armed` ← 1. Otherwise sat(per_cnt+1). First rise after reset or timeout arms only, no strobe.
- Idle counter: any edge → 0; else sat(+1). Reaching TIMEOUT_CYC → `timeout` ← 1, `armed` ← 0, `hi_cnt`/`per_cnt` ← 0. `timeout` stays 1 until next rise, cleared in that rise's cycle. `high_len`/`period_len` hold last values through timeout.
- Channels fully independent; no shared state other than clock and reset.
- Reset (`reset_n`=0) overrides all other events, including a same-cycle edge.

## Timing
- Reset values: `high_len`, `period_len` = 0; `high_valid`, `period_valid`, `timeout` = 0; synchroniser flops, `s_d`, counters, `armed` = 0.
- Latency: pin edge sampled at clock k → result and strobe registered, visible after edge k+SYNC_STAGES+1.
- Strobes are exactly one cycle; a strobe never repeats without a new edge.
- Minimum resolvable high or low phase: 1 cycle of `s`; shorter pin glitches may be lost by synchroniser (allowed).
- Reset mid-pulse: partial count discarded; the next fall after release is ignored (not armed).
- Saturated measurement publishes 2^CNT_W−1.

## Configuration
- `PWM_CAPTURE_PERIOD_EN` defined: period counter, `period_len`, `period_valid` implemented as above.
- Undefined: no period logic; `period_len` tied to 0, `period_valid` tied to 0; high-time and timeout behaviour unchanged.

## Structure
- `pwm_capture_pkg`: result-width helper, saturating-increment function, `SYNC_STAGES` minimum constant.
- Sub-module `pwm_capture_ch`: one channel (synchroniser, edge detect, counters, timeout); top generates NUM_CH instances and packs outputs.

## Test plan
- Reset then 12-cycle high, 8-cycle low, repeated twice → first fall ignored? no: armed by first rise, so `high_len`=12 strobe each fall; `period_len`=20 on second and third rises only.
- Back-to-back 24- then 48-cycle highs, 10-cycle lows → `high_len` 24 then 48, each with single `high_valid`; latency SYNC_STAGES+1 from pin.
- CNT_W=4, 20-cycle high → `high_len`=15 (saturated), one strobe.
- TIMEOUT_CYC=50, input held low 60 cycles → `timeout`=1 at cycle 50 idle; next rise clears it, arms only, no `period_valid`.
- `reset_n` low at cycle 5 of a 12-cycle high, released → no strobe at that fall; next full 12-cycle pulse reports 12.
- NUM_CH=3, channels driven 10/20/30-cycle highs concurrently → each slice reports own value; macro undefined build → `period_valid` never asserts.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared helpers for pwm_capture: bus sizing, saturating increment, synchroniser floor.
// Counters wider than CNT_W_MAX bits are not supported by sat_inc.
package pwm_capture_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int CNT_W_MAX       = 64;

  function automatic int res_w(input int num_ch, input int cnt_w);
    return num_ch * cnt_w;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] v,
                                                   input int w);
    logic [CNT_W_MAX-1:0] max_v;
    max_v = (w >= CNT_W_MAX) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchroniser, edge detect, high/period/idle counters, timeout.
// Results appear SYNC_STAGES+1 clocks after the pin edge is first sampled.
module pwm_capture_ch
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] high_len_o,
  output logic             high_valid_o,
  output logic [CNT_W-1:0] period_len_o,
  output logic             period_valid_o,
  output logic             timeout_o
);

  localparam int               PRIME_W    = SYNC_STAGES + 2;
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(CNT_W_MAX'(v), CNT_W));
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRIME_W-1:0]     prime_q;
  logic                   s_q, s_d_q;
  logic [CNT_W-1:0]       hi_q, hi_d, idle_q, idle_d, high_len_q, high_len_d;
  logic                   armed_q, armed_d, timeout_q, timeout_d;
  logic                   high_valid_q, high_valid_d;
  logic                   rise, fall, timeout_hit;

  // Edges are qualified only once s_q and s_d_q both hold post-reset pin samples,
  // so a pin already high at reset release is not mistaken for a rise.
  assign rise        = prime_q[PRIME_W-1] & s_q & ~s_d_q;
  assign fall        = prime_q[PRIME_W-1] & ~s_q & s_d_q;
  assign timeout_hit = ~rise & ~fall & (idle_q == TIMEOUT_M1);

  always_comb begin
    hi_d         = hi_q;
    idle_d       = idle_q;
    armed_d      = armed_q;
    timeout_d    = timeout_q;
    high_len_d   = high_len_q;
    high_valid_d = 1'b0;
    if (rise) begin
      hi_d      = ONE;
      idle_d    = '0;
      armed_d   = 1'b1;
      timeout_d = 1'b0;
    end else if (fall) begin
      if (armed_q) begin
        high_len_d   = hi_q;
        high_valid_d = 1'b1;
      end
      hi_d   = '0;
      idle_d = '0;
    end else begin
      if (s_q) hi_d = inc(hi_q);
      if (idle_q != TIMEOUT_V) idle_d = inc(idle_q);
      if (timeout_hit) begin
        timeout_d = 1'b1;
        armed_d   = 1'b0;
        hi_d      = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync_q       <= '0;
      prime_q      <= '0;
      s_q          <= 1'b0;
      s_d_q        <= 1'b0;
      hi_q         <= '0;
      idle_q       <= '0;
      armed_q      <= 1'b0;
      timeout_q    <= 1'b0;
      high_len_q   <= '0;
      high_valid_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prime_q      <= {prime_q[PRIME_W-2:0], 1'b1};
      s_q          <= sync_q[SYNC_STAGES-1];
      s_d_q        <= s_q;
      hi_q         <= hi_d;
      idle_q       <= idle_d;
      armed_q      <= armed_d;
      timeout_q    <= timeout_d;
      high_len_q   <= high_len_d;
      high_valid_q <= high_valid_d;
    end
  end

  assign high_len_o   = high_len_q;
  assign high_valid_o = high_valid_q;
  assign timeout_o    = timeout_q;

`ifdef PWM_CAPTURE_PERIOD_EN
  logic [CNT_W-1:0] per_q, per_d, period_len_q, period_len_d;
  logic             period_valid_q, period_valid_d;

  always_comb begin
    per_d          = per_q;
    period_len_d   = period_len_q;
    period_valid_d = 1'b0;
    if (rise) begin
      if (armed_q) begin
        period_len_d   = per_q;
        period_valid_d = 1'b1;
      end
      per_d = ONE;
    end else if (timeout_hit) begin
      per_d = '0;
    end else begin
      per_d = inc(per_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      per_q          <= '0;
      period_len_q   <= '0;
      period_valid_q <= 1'b0;
    end else begin
      per_q          <= per_d;
      period_len_q   <= period_len_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign period_len_o   = period_len_q;
  assign period_valid_o = period_valid_q;
`else
  assign period_len_o   = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM high-time / period capture with stall timeout; NUM_CH independent channels.
// Period measurement exists only when PWM_CAPTURE_PERIOD_EN is defined, else period outputs read 0.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CH-1:0]                 pwm,
  output logic [res_w(NUM_CH, CNT_W)-1:0]   high_len,
  output logic [NUM_CH-1:0]                 high_valid,
  output logic [res_w(NUM_CH, CNT_W)-1:0]   period_len,
  output logic [NUM_CH-1:0]                 period_valid,
  output logic [NUM_CH-1:0]                 timeout
);

  // Fewer than two synchroniser flops is never safe on an asynchronous pin.
  localparam int SYNC_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_capture_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_EFF),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .pwm_i          (pwm[i]),
      .high_len_o     (high_len[i*CNT_W +: CNT_W]),
      .high_valid_o   (high_valid[i]),
      .period_len_o   (period_len[i*CNT_W +: CNT_W]),
      .period_valid_o (period_valid[i]),
      .timeout_o      (timeout[i])
    );
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (3ch/16b/2 sync/50 timeout and 1ch/4b/3 sync/15 timeout)
// checked every cycle against a timestamp-based reference model.
module tb_pwm_capture;

  localparam int NA = 3, WA = 16, SA = 2, TA = 50;
  localparam int WB = 4, SB = 3, TB = 15;
`ifdef PWM_CAPTURE_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        pin;
  logic [NA-1:0]     pwm_a;
  logic [0:0]        pwm_b;
  logic [NA*WA-1:0]  high_len_a, period_len_a;
  logic [NA-1:0]     high_valid_a, period_valid_a, timeout_a;
  logic [WB-1:0]     high_len_b, period_len_b;
  logic [0:0]        high_valid_b, period_valid_b, timeout_b;

  assign pwm_a = pin[2:0];
  assign pwm_b = pin[3];

  always #5 clk = ~clk;

  pwm_capture #(.NUM_CH(NA), .CNT_W(WA), .SYNC_STAGES(SA), .TIMEOUT_CYC(TA)) dut_a (
    .clk(clk), .reset_n(reset_n), .pwm(pwm_a),
    .high_len(high_len_a), .high_valid(high_valid_a),
    .period_len(period_len_a), .period_valid(period_valid_a), .timeout(timeout_a));

  pwm_capture #(.NUM_CH(1), .CNT_W(WB), .SYNC_STAGES(SB), .TIMEOUT_CYC(TB)) dut_b (
    .clk(clk), .reset_n(reset_n), .pwm(pwm_b),
    .high_len(high_len_b), .high_valid(high_valid_b),
    .period_len(period_len_b), .period_valid(period_valid_b), .timeout(timeout_b));

  // Model channels 0..2 are dut_a, channel 3 is dut_b. Times are output-edge indices.
  int lat[4], maxv[4], tmo[4];
  int armed[4], prev[4], prev_ok[4], rise_t[4], ref_t[4], m_hl[4], m_pl[4], m_to[4];
  int r_hl[4][64], r_hv[4][64], r_pl[4][64], r_pv[4][64], r_to[4][64];
  int p_hi[4], p_lo[4], p_cnt[4];
  int t, n_vec, n_fail;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic put(input int c, input int idx, input int hv, input int pv);
    r_hl[c][idx % 64] = m_hl[c];
    r_pl[c][idx % 64] = m_pl[c];
    r_to[c][idx % 64] = m_to[c];
    r_hv[c][idx % 64] = hv;
    r_pv[c][idx % 64] = pv;
  endtask

  // Pin sample at edge t determines the outputs registered at edge t+lat.
  task automatic model_edge(input int c, input logic p, input logic rs);
    int o;
    int hv, pv;
    if (!rs) begin
      armed[c] = 0; prev_ok[c] = 0; m_hl[c] = 0; m_pl[c] = 0; m_to[c] = 0; ref_t[c] = t;
      for (int k = 0; k <= lat[c]; k++) put(c, t + k, 0, 0);
      return;
    end
    o = t + lat[c];
    hv = 0;
    pv = 0;
    if (prev_ok[c] != 0 && p && prev[c] == 0) begin
      if (armed[c] != 0 && PER_EN) begin
        m_pl[c] = mn(o - rise_t[c], maxv[c]);
        pv = 1;
      end
      rise_t[c] = o; armed[c] = 1; m_to[c] = 0; ref_t[c] = o;
    end else if (prev_ok[c] != 0 && !p && prev[c] != 0) begin
      if (armed[c] != 0) begin
        m_hl[c] = mn(o - rise_t[c], maxv[c]);
        hv = 1;
      end
      ref_t[c] = o;
    end else if (o - ref_t[c] == tmo[c]) begin
      m_to[c] = 1;
      armed[c] = 0;
    end
    prev[c] = int'(p);
    prev_ok[c] = 1;
    put(c, o, hv, pv);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, t);
    end
  endtask

  task automatic cyc();
    logic        rs;
    logic [3:0]  pv;
    logic [63:0] e_hl, e_pl, e_hv, e_pv, e_to;
    int          s;
    rs = reset_n;
    pv = pin;
    @(posedge clk);
    for (int c = 0; c < 4; c++) model_edge(c, pv[c], rs);
    #1;
    s = t % 64;
    e_hl = '0; e_pl = '0; e_hv = '0; e_pv = '0; e_to = '0;
    for (int c = 0; c < NA; c++) begin
      e_hl[c*WA +: WA] = WA'(r_hl[c][s]);
      e_pl[c*WA +: WA] = WA'(r_pl[c][s]);
      e_hv[c] = (r_hv[c][s] != 0);
      e_pv[c] = (r_pv[c][s] != 0);
      e_to[c] = (r_to[c][s] != 0);
    end
    check("A.high_len",     64'(high_len_a),     e_hl);
    check("A.high_valid",   64'(high_valid_a),   e_hv);
    check("A.period_len",   64'(period_len_a),   e_pl);
    check("A.period_valid", 64'(period_valid_a), e_pv);
    check("A.timeout",      64'(timeout_a),      e_to);
    check("B.high_len",     64'(high_len_b),     64'(r_hl[3][s]));
    check("B.high_valid",   64'(high_valid_b),   64'(r_hv[3][s]));
    check("B.period_len",   64'(period_len_b),   64'(r_pl[3][s]));
    check("B.period_valid", 64'(period_valid_b), 64'(r_pv[3][s]));
    check("B.timeout",      64'(timeout_b),      64'(r_to[3][s]));
    t++;
  endtask

  task automatic set_pat(input int c, input int hi, input int lo);
    p_hi[c] = hi;
    p_lo[c] = lo;
    p_cnt[c] = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      for (int c = 0; c < 4; c++) begin
        pin[c] = (p_cnt[c] < p_hi[c]);
        p_cnt[c] = (p_cnt[c] + 1) % (p_hi[c] + p_lo[c]);
      end
      cyc();
    end
  endtask

  initial begin
    t = 0; n_vec = 0; n_fail = 0;
    for (int c = 0; c < 4; c++) begin
      lat[c]  = (c < 3) ? SA + 1 : SB + 1;
      maxv[c] = (c < 3) ? (1 << WA) - 1 : (1 << WB) - 1;
      tmo[c]  = (c < 3) ? TA : TB;
      armed[c] = 0; prev[c] = 0; prev_ok[c] = 0; rise_t[c] = 0; ref_t[c] = 0;
      m_hl[c] = 0; m_pl[c] = 0; m_to[c] = 0;
      for (int k = 0; k < 64; k++) put(c, k, 0, 0);
      set_pat(c, 0, 1);
    end
    pin = '0;
    reset_n = 1'b0;
    run(5);
    check("rst.high_len_a", 64'(high_len_a), 64'd0);
    check("rst.timeout_a", 64'(timeout_a), 64'd0);
    reset_n = 1'b1;
    run(10);

    // 12 high / 8 low; dut_b 10/10 so its 20-cycle period saturates at 15
    set_pat(0, 12, 8);
    set_pat(3, 10, 10);
    run(60);
    check("t1.high_len0", 64'(high_len_a[15:0]), 64'd12);
    check("t1.period_len0", 64'(period_len_a[15:0]), PER_EN ? 64'd20 : 64'd0);
    check("t1.b_high_len", 64'(high_len_b), 64'd10);
    check("t1.b_period_sat", 64'(period_len_b), PER_EN ? 64'd15 : 64'd0);

    // back-to-back 24 then 48 highs; dut_b high longer than its timeout
    set_pat(0, 24, 10);
    set_pat(3, 20, 5);
    run(34);
    check("t2.high_len0_24", 64'(high_len_a[15:0]), 64'd24);
    set_pat(0, 48, 10);
    run(58);
    check("t2.high_len0_48", 64'(high_len_a[15:0]), 64'd48);

    // concurrent independent channels
    set_pat(0, 10, 7);
    set_pat(1, 20, 7);
    set_pat(2, 30, 7);
    set_pat(3, 6, 3);
    run(120);
    check("t3.high_len_all", 64'(high_len_a), {16'd0, 16'd30, 16'd20, 16'd10});

    // idle until timeout, then resume
    for (int c = 0; c < 4; c++) set_pat(c, 0, 1);
    run(70);
    check("t4.timeout_a", 64'(timeout_a), 64'h7);
    check("t4.timeout_b", 64'(timeout_b), 64'h1);
    for (int c = 0; c < 4; c++) set_pat(c, 6, 6);
    run(30);

    // reset in the middle of a 12-cycle high
    set_pat(0, 12, 8);
    set_pat(1, 0, 1);
    set_pat(2, 0, 1);
    run(5);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(45);
    check("t5.high_len0", 64'(high_len_a[15:0]), 64'd12);

    // randomized segments, including held-low channels and a mid-run reset
    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < 3; c++) set_pat(c, $urandom_range(0, 40), $urandom_range(1, 40));
      set_pat(3, $urandom_range(1, 18), $urandom_range(1, 14));
      run($urandom_range(60, 160));
      if (it == 6) begin
        reset_n = 1'b0;
        run($urandom_range(1, 3));
        reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
